// File: rtl/player_input_pkg.sv
// Shared types and widths for the player input conditioning stage.
// BTN_NUM_W matches the game core's playerNum/simonNum width.
package player_input_pkg;

  localparam int NUM_BUTTONS = 4;
  localparam int BTN_NUM_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PULSE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Bit 0 has the highest priority, so the lowest set index wins.
  function automatic logic [BTN_NUM_W-1:0] prio_enc(input logic [NUM_BUTTONS-1:0] b);
    logic [BTN_NUM_W-1:0] idx;
    idx = {BTN_NUM_W{1'b0}};
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (b[i]) begin
        idx = BTN_NUM_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
module btn_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Metastability chain: d -> meta_r -> q.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= {WIDTH{1'b0}};
      q      <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/player_input.sv
// Debounces the four player buttons and emits one press pulse with the
// button number per physical press, gated by the game core's enable.
module player_input
  import player_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int RELEASE_TICKS  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn,
  input  logic                   enable,
  output logic [BTN_NUM_W-1:0]   playerNum,
  output logic                   playerPressed,
  output logic                   busy
);

  localparam int MAX_TICKS = (DEBOUNCE_TICKS > RELEASE_TICKS) ? DEBOUNCE_TICKS : RELEASE_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_TICKS - 1);

  logic [NUM_BUTTONS-1:0] bs_s;
  logic                   any_s;
  logic                   cand_held_s;
  logic [BTN_NUM_W-1:0]   enc_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [BTN_NUM_W-1:0]   cand_r;

  btn_sync #(.WIDTH(NUM_BUTTONS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (bs_s)
  );

  assign any_s       = |bs_s;
  assign cand_held_s = bs_s[cand_r];
  assign enc_s       = prio_enc(bs_s);

  // Press FSM; busy tracks the next state so it equals (state != IDLE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      cand_r        <= {BTN_NUM_W{1'b0}};
      playerNum     <= {BTN_NUM_W{1'b0}};
      playerPressed <= 1'b0;
      busy          <= 1'b0;
    end else begin
      playerPressed <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s && enable) begin
            cand_r  <= enc_s;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= QUALIFY;
            busy    <= 1'b1;
          end else if (any_s) begin
            // Pressed during Simon's turn: must be released before it can count.
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= RELEASE;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        QUALIFY: begin
          if (!enable || !cand_held_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (cnt_r == DEB_LAST) begin
            state_r       <= PULSE;
            playerPressed <= 1'b1;
            playerNum     <= cand_r;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        PULSE: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= RELEASE;
        end
        RELEASE: begin
          if (any_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (cnt_r == REL_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
